pid_pwm_fan_driver: RTL and testbench

//  Downstream stage of the PID core. It takes the signed controller output and the PID sample strobe,

---
 rtl/pid_pwm_fan_driver.sv | 135 +++++++++++++
 tb/tb_pid_pwm_fan_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_fan_driver.sv
// Fan PWM stage behind the PID core: clamp/quantize, period-aligned duty updates, spin-up kick.
// Optional feature macro PWM_MIN_DUTY_EN raises nonzero duties below MIN_DUTY to MIN_DUTY.
module pid_pwm_fan_driver #(
  parameter int ADC_BITWIDTH = 8,
  parameter int PWM_BITWIDTH = 4,
  parameter int PRESCALE     = 16,
  parameter int KICK_PERIODS = 8,
  parameter int MIN_DUTY     = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    pid_valid_i,
  input  logic [ADC_BITWIDTH:0]   pid_val_i,
  input  logic                    enable_i,
  output logic                    pwm_o,
  output logic [PWM_BITWIDTH-1:0] duty_o,
  output logic                    fan_running_o,
  output logic                    period_end_o
);

  localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int KICK_W = (KICK_PERIODS > 1) ? $clog2(KICK_PERIODS) : 1;
  localparam logic [PRE_W-1:0]        PRE_LAST  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITWIDTH-1:0] PWM_LAST  = PWM_BITWIDTH'((2 ** PWM_BITWIDTH) - 2);
  localparam logic [KICK_W-1:0]       KICK_LOAD = KICK_W'(KICK_PERIODS - 1);

  typedef enum logic [1:0] {IDLE, KICK, RUN} state_t;

  state_t                  state, state_next;
  logic [PRE_W-1:0]        pre_cnt;
  logic [PWM_BITWIDTH-1:0] pwm_cnt;
  logic [PWM_BITWIDTH-1:0] pending;
  logic [PWM_BITWIDTH-1:0] duty_active, duty_next;
  logic [KICK_W-1:0]       kick_cnt, kick_next;
  logic                    tick;
  logic                    period_end;

`ifdef PWM_MIN_DUTY_EN
  localparam logic [PWM_BITWIDTH-1:0] MIN_D = PWM_BITWIDTH'(MIN_DUTY);

  function automatic logic [PWM_BITWIDTH-1:0] eff(input logic [PWM_BITWIDTH-1:0] p);
    if ((p != '0) && (p < MIN_D)) return MIN_D;
    return p;
  endfunction
`else
  function automatic logic [PWM_BITWIDTH-1:0] eff(input logic [PWM_BITWIDTH-1:0] p);
    return p;
  endfunction
`endif

  // Low PID bits are dropped by truncation; MIN_DUTY matters only with the min-duty option.
  logic unused_bits;
  assign unused_bits = ^{pid_val_i[ADC_BITWIDTH-PWM_BITWIDTH-1:0], (MIN_DUTY != 0)};

  assign tick       = (pre_cnt == PRE_LAST);
  assign period_end = tick && (pwm_cnt == PWM_LAST);
  assign duty_o     = duty_active;

  always_comb begin
    state_next = state;
    duty_next  = duty_active;
    kick_next  = kick_cnt;
    if (!enable_i) begin
      state_next = IDLE;
      duty_next  = '0;
      kick_next  = '0;
    end else if (period_end) begin
      case (state)
        IDLE: begin
          duty_next = '0;
          if (pending != '0) begin
            state_next = KICK;
            duty_next  = '1;
            kick_next  = KICK_LOAD;
          end
        end
        KICK: begin
          if (kick_cnt != '0) begin
            kick_next = kick_cnt - 1'b1;
          end else if (pending == '0) begin
            state_next = IDLE;
            duty_next  = '0;
          end else begin
            state_next = RUN;
            duty_next  = eff(pending);
          end
        end
        RUN: begin
          if (pending == '0) begin
            state_next = IDLE;
            duty_next  = '0;
          end else begin
            duty_next = eff(pending);
          end
        end
        default: begin
          state_next = IDLE;
          duty_next  = '0;
        end
      endcase
    end
  end

  // Counters free-run regardless of enable so period boundaries stay on a fixed grid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_cnt       <= '0;
      pwm_cnt       <= '0;
      pending       <= '0;
      state         <= IDLE;
      duty_active   <= '0;
      kick_cnt      <= '0;
      fan_running_o <= 1'b0;
      pwm_o         <= 1'b0;
      period_end_o  <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
      end
      if (!enable_i) begin
        pending <= '0;
      end else if (pid_valid_i) begin
        pending <= pid_val_i[ADC_BITWIDTH] ? '0 : pid_val_i[ADC_BITWIDTH-1 -: PWM_BITWIDTH];
      end
      state         <= state_next;
      duty_active   <= duty_next;
      kick_cnt      <= kick_next;
      fan_running_o <= (state_next != IDLE);
      pwm_o         <= enable_i && (state != IDLE) && (pwm_cnt < duty_active);
      period_end_o  <= period_end;
    end
  end

endmodule

// File: tb/tb_pid_pwm_fan_driver.sv
// Self-checking bench for pid_pwm_fan_driver: period-by-period vector table with a scoreboard,
// plus hand-written sequences for coincident strobe/period end and reset during KICK.
module tb_pid_pwm_fan_driver;

  localparam int ADC_BITWIDTH = 8;
  localparam int PWM_BITWIDTH = 4;
  localparam int PRESCALE     = 16;
  localparam int KICK_PERIODS = 8;
  localparam int MIN_DUTY     = 3;
  localparam int PERIOD_CLK   = ((2 ** PWM_BITWIDTH) - 1) * PRESCALE;
`ifdef PWM_MIN_DUTY_EN
  localparam int EXP_LOW_DUTY = 3;
`else
  localparam int EXP_LOW_DUTY = 1;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    pid_valid;
  logic [ADC_BITWIDTH:0]   pid_val;
  logic                    enable;
  logic                    pwm;
  logic [PWM_BITWIDTH-1:0] duty;
  logic                    running;
  logic                    pe;

  typedef struct {
    bit                    strobe;
    logic [ADC_BITWIDTH:0] val;
    bit                    en;
    int                    duty;
    bit                    run;
  } vec_t;

  typedef struct {
    int row;
    int duty;
    int run;
    int high;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   nChecks = 0;
  int   nFails  = 0;

  pid_pwm_fan_driver #(
    .ADC_BITWIDTH(ADC_BITWIDTH),
    .PWM_BITWIDTH(PWM_BITWIDTH),
    .PRESCALE    (PRESCALE),
    .KICK_PERIODS(KICK_PERIODS),
    .MIN_DUTY    (MIN_DUTY)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .pid_valid_i  (pid_valid),
    .pid_val_i    (pid_val),
    .enable_i     (enable),
    .pwm_o        (pwm),
    .duty_o       (duty),
    .fan_running_o(running),
    .period_end_o (pe)
  );

  always #5 clk = ~clk;

  initial begin
    #(60000 * 10);
    $display("[TB] FAIL watchdog: time limit reached before end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: actual %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void addRow(input bit strobe, input logic [ADC_BITWIDTH:0] val,
                                 input bit en, input int d, input bit run);
    vec_t v;
    v.strobe = strobe;
    v.val    = val;
    v.en     = en;
    v.duty   = d;
    v.run    = run;
    vecs.push_back(v);
  endfunction

  // Called on a period_end_o sample; the window that follows runs at the previous duty.
  task automatic applyStimulus(input int row, input int prevDuty);
    exp_t e;
    enable = vecs[row].en;
    if (vecs[row].strobe) begin
      pid_valid = 1'b1;
      pid_val   = vecs[row].val;
    end
    e.row  = row;
    e.duty = vecs[row].duty;
    e.run  = vecs[row].run;
    e.high = vecs[row].en ? prevDuty * PRESCALE : 0;
    sbq.push_back(e);
  endtask

  task automatic measureWindow(output int highs, output int peCount, output bit peLast);
    highs   = 0;
    peCount = 0;
    peLast  = 1'b0;
    for (int i = 1; i <= PERIOD_CLK; i++) begin
      @(negedge clk);
      pid_valid = 1'b0;
      if (pwm === 1'b1) highs++;
      if (pe === 1'b1) peCount++;
      if (i == PERIOD_CLK) peLast = (pe === 1'b1);
    end
  endtask

  task automatic waitPeriodEnd(output int cnt);
    bit found;
    cnt   = 0;
    found = 1'b0;
    while (!found && cnt < PERIOD_CLK + 60) begin
      @(negedge clk);
      cnt++;
      if (pe === 1'b1) found = 1'b1;
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " pwm_o"}, 32'(pwm), 0);
    checkOutput({tag, " duty_o"}, 32'(duty), 0);
    checkOutput({tag, " fan_running_o"}, 32'(running), 0);
    checkOutput({tag, " period_end_o"}, 32'(pe), 0);
  endtask

  initial begin
    int   prevDuty;
    int   highs, peCount, cnt;
    bit   peLast;
    exp_t e;

    addRow(1, 9'h080, 1, 15, 1);
    repeat (KICK_PERIODS - 1) addRow(0, 9'h000, 1, 15, 1);
    addRow(0, 9'h000, 1, 8, 1);
    addRow(0, 9'h000, 1, 8, 1);
    addRow(1, 9'h1FB, 1, 0, 0);
    addRow(0, 9'h000, 1, 0, 0);
    addRow(1, 9'h010, 1, 15, 1);
    repeat (KICK_PERIODS - 1) addRow(0, 9'h000, 1, 15, 1);
    addRow(0, 9'h000, 1, EXP_LOW_DUTY, 1);
    addRow(0, 9'h000, 1, EXP_LOW_DUTY, 1);
    addRow(1, 9'h0F7, 1, 15, 1);
    addRow(1, 9'h05A, 1, 5, 1);
    addRow(0, 9'h000, 0, 0, 0);
    addRow(1, 9'h0C0, 1, 15, 1);
    addRow(0, 9'h000, 0, 0, 0);
    addRow(1, 9'h080, 1, 15, 1);
    repeat (KICK_PERIODS - 1) addRow(0, 9'h000, 1, 15, 1);
    addRow(0, 9'h000, 1, 8, 1);

    rst       = 1'b1;
    pid_valid = 1'b0;
    pid_val   = '0;
    enable    = 1'b1;
    repeat (3) @(negedge clk);
    checkResetOutputs("initial reset");
    rst = 1'b0;

    waitPeriodEnd(cnt);
    checkOutput("first period length", 32'(cnt), PERIOD_CLK);

    prevDuty = 0;
    for (int r = 0; r < vecs.size(); r++) begin
      applyStimulus(r, prevDuty);
      measureWindow(highs, peCount, peLast);
      e = sbq.pop_front();
      checkOutput($sformatf("row%0d duty_o", e.row), 32'(duty), e.duty);
      checkOutput($sformatf("row%0d fan_running_o", e.row), 32'(running), e.run);
      checkOutput($sformatf("row%0d pwm high clk", e.row), 32'(highs), e.high);
      checkOutput($sformatf("row%0d period_end pulses", e.row), 32'(peCount), 1);
      checkOutput($sformatf("row%0d period_end at window end", e.row), 32'(peLast), 1);
      prevDuty = e.duty;
    end

    // Strobe landing on the period_end cycle: the old pending (8) is applied first.
    pid_valid = 1'b1;
    pid_val   = 9'h080;
    @(negedge clk);
    pid_valid = 1'b0;
    repeat (PERIOD_CLK - 2) @(negedge clk);
    pid_valid = 1'b1;
    pid_val   = 9'h040;
    @(negedge clk);
    pid_valid = 1'b0;
    checkOutput("coincident period_end_o", 32'(pe), 1);
    checkOutput("coincident duty_o first", 32'(duty), 8);
    measureWindow(highs, peCount, peLast);
    checkOutput("coincident pwm high clk", 32'(highs), 8 * PRESCALE);
    checkOutput("coincident duty_o second", 32'(duty), 4);
    checkOutput("coincident period_end at window end", 32'(peLast), 1);

    // Drop to IDLE, arm a kick, then reset in the middle of it.
    enable = 1'b0;
    @(negedge clk);
    checkOutput("disable duty_o", 32'(duty), 0);
    checkOutput("disable fan_running_o", 32'(running), 0);
    enable    = 1'b1;
    pid_valid = 1'b1;
    pid_val   = 9'h080;
    @(negedge clk);
    pid_valid = 1'b0;
    waitPeriodEnd(cnt);
    checkOutput("kick entry duty_o", 32'(duty), 15);
    checkOutput("kick entry fan_running_o", 32'(running), 1);
    repeat (100) @(negedge clk);
    checkOutput("mid-kick pwm_o", 32'(pwm), 1);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkResetOutputs($sformatf("mid-kick reset cycle%0d", i));
    end
    rst = 1'b0;
    waitPeriodEnd(cnt);
    checkOutput("post-reset period length", 32'(cnt), PERIOD_CLK);
    checkOutput("post-reset duty_o", 32'(duty), 0);
    checkOutput("post-reset fan_running_o", 32'(running), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
